// File: rtl/systolic_skew_feeder.sv
// rtl/systolic_skew_feeder.sv - diagonal skew feeder for the left edge of the systolic PE array
module systolic_skew_feeder #(
    parameter int ROWS = 4,
    parameter int DW   = 8,
    parameter int CNTW = 16
) (
    input  logic                 clock,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ROWS*DW-1:0]   in_data,
    input  logic                 in_last,
    output logic [ROWS*DW-1:0]   data_out,
    output logic                 active_out,
    output logic                 busy,
    output logic                 done,
    output logic [CNTW-1:0]      vec_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Drain needs ROWS-1 zero-fill advances; a single-row array has nothing to drain.
    localparam int             DCW        = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'((ROWS > 1) ? ROWS - 2 : 0);
    localparam state_t         AFTER_LAST = (ROWS > 1) ? DRAIN : DONE;

    state_t         state;
    logic [DCW-1:0] drain_cnt;
    logic           acc;
    logic           adv;

    assign in_ready = en & ((state == IDLE) | (state == STREAM));
    assign acc      = in_valid & in_ready;
    assign adv      = acc | (state == DRAIN);
    assign busy     = (state != IDLE);

    // Tile control: vector counting, drain sequencing, and the registered active/done outputs.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            drain_cnt  <= '0;
            vec_count  <= '0;
            active_out <= 1'b0;
            done       <= 1'b0;
        end else begin
            active_out <= adv;
            done       <= (state == DONE);
            case (state)
                IDLE: begin
                    if (acc) begin
                        vec_count <= CNTW'(1);
                        drain_cnt <= '0;
                        state     <= in_last ? AFTER_LAST : STREAM;
                    end
                end
                STREAM: begin
                    if (acc) begin
                        if (vec_count != {CNTW{1'b1}}) begin
                            vec_count <= vec_count + 1'b1;
                        end
                        if (in_last) begin
                            drain_cnt <= '0;
                            state     <= AFTER_LAST;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        drain_cnt <= '0;
                        state     <= DONE;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                DONE: begin
                    drain_cnt <= '0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Row r sees r internal stages plus the output register, so it lags row 0 by r advances.
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        logic [DW-1:0] din;
        logic [DW-1:0] q;

        // Zero fill during drain; in_data is ignored whenever nothing is accepted.
        assign din = acc ? in_data[r*DW +: DW] : '0;
        assign data_out[r*DW +: DW] = q;

        if (r == 0) begin : g_direct
            // Row 0 goes straight into the output register.
            always_ff @(posedge clock or negedge rst_n) begin
                if (!rst_n) begin
                    q <= '0;
                end else if (adv) begin
                    q <= din;
                end
            end
        end else begin : g_chain
            logic [DW-1:0] sh [r];

            // Shift the delay chain only on an advance so the whole diagonal stalls together.
            always_ff @(posedge clock or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < r; i++) begin
                        sh[i] <= '0;
                    end
                    q <= '0;
                end else if (adv) begin
                    sh[0] <= din;
                    for (int i = 1; i < r; i++) begin
                        sh[i] <= sh[i-1];
                    end
                    q <= sh[r-1];
                end
            end
        end
    end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// tb/tb_systolic_skew_feeder.sv - self-checking bench for systolic_skew_feeder
module tb_systolic_skew_feeder;

    localparam int ROWS = 4;
    localparam int DW   = 8;
    localparam int CNTW = 16;

    logic               clock;
    logic               rst_n;
    logic               en;
    logic               in_valid;
    logic               in_ready;
    logic [ROWS*DW-1:0] in_data;
    logic               in_last;
    logic [ROWS*DW-1:0] data_out;
    logic               active_out;
    logic               busy;
    logic               done;
    logic [CNTW-1:0]    vec_count;

    logic               en1;
    logic               in_valid1;
    logic               in_ready1;
    logic [DW-1:0]      in_data1;
    logic               in_last1;
    logic [DW-1:0]      data_out1;
    logic               active_out1;
    logic               busy1;
    logic               done1;
    logic [CNTW-1:0]    vec_count1;

    systolic_skew_feeder #(.ROWS(ROWS), .DW(DW), .CNTW(CNTW)) dut (
        .clock      (clock),
        .rst_n      (rst_n),
        .en         (en),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .data_out   (data_out),
        .active_out (active_out),
        .busy       (busy),
        .done       (done),
        .vec_count  (vec_count)
    );

    systolic_skew_feeder #(.ROWS(1), .DW(DW), .CNTW(CNTW)) dut1 (
        .clock      (clock),
        .rst_n      (rst_n),
        .en         (en1),
        .in_valid   (in_valid1),
        .in_ready   (in_ready1),
        .in_data    (in_data1),
        .in_last    (in_last1),
        .data_out   (data_out1),
        .active_out (active_out1),
        .busy       (busy1),
        .done       (done1),
        .vec_count  (vec_count1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        bit          en;
        bit          valid;
        bit          last;
        logic [31:0] data;
        bit          exp_ready;
        bit          exp_adv;
        bit          exp_done;
        bit          exp_busy;
        int          exp_cnt;
    } vec_t;

    localparam logic [31:0] V0 = 32'h04030201;
    localparam logic [31:0] V1 = 32'h08070605;
    localparam logic [31:0] V2 = 32'h0C0B0A09;
    localparam logic [31:0] V3 = 32'h100F0E0D;
    localparam logic [31:0] VS = 32'h7F80FF07;

    vec_t        tbl[$];
    logic [31:0] sb[$];
    logic [31:0] exp_data;
    int          checks;
    int          errors;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input bit e, input bit v, input bit l, input logic [31:0] d,
                       input bit rdy, input bit a, input bit dn, input bit b, input int cnt);
        vec_t t;
        t.en = e; t.valid = v; t.last = l; t.data = d;
        t.exp_ready = rdy; t.exp_adv = a; t.exp_done = dn; t.exp_busy = b; t.exp_cnt = cnt;
        tbl.push_back(t);
    endtask

    task automatic sb_reset();
        sb.delete();
        for (int i = 0; i < ROWS - 1; i++) sb.push_back(32'h0);
        exp_data = 32'h0;
    endtask

    // Expected vector (or zero fill) enters the scoreboard on each advance; row r reads r back.
    task automatic sb_advance(input logic [31:0] v);
        logic [31:0] e;
        sb.push_back(v);
        for (int r = 0; r < ROWS; r++) begin
            e = sb[sb.size() - 1 - r];
            exp_data[r*DW +: DW] = e[r*DW +: DW];
        end
        if (sb.size() > ROWS) void'(sb.pop_front());
    endtask

    task automatic run_table(input string tag);
        vec_t t;
        for (int i = 0; i < tbl.size(); i++) begin
            t = tbl[i];
            en       = t.en;
            in_valid = t.valid;
            in_last  = t.last;
            in_data  = t.data;
            #1;
            chk($sformatf("%s[%0d].in_ready", tag, i), in_ready, t.exp_ready);
            if (t.exp_adv) sb_advance((t.valid && t.exp_ready) ? t.data : 32'h0);
            @(posedge clock);
            #1;
            chk($sformatf("%s[%0d].active", tag, i), active_out, t.exp_adv);
            chk($sformatf("%s[%0d].done", tag, i), done, t.exp_done);
            chk($sformatf("%s[%0d].busy", tag, i), busy, t.exp_busy);
            chk($sformatf("%s[%0d].vec_count", tag, i), vec_count, t.exp_cnt);
            chk($sformatf("%s[%0d].data_out", tag, i), data_out, exp_data);
        end
        tbl.delete();
    endtask

    task automatic add_drain_done(input bit e, input int cnt);
        for (int k = 0; k < ROWS - 1; k++) add(e, 0, 0, $urandom, 0, 1, 0, 1, cnt);
        add(e, 0, 0, $urandom, 0, 0, 1, 0, cnt);
        add(1, 0, 0, $urandom, 1, 0, 0, 0, cnt);
    endtask

    task automatic load_tile1();
        add(1, 1, 0, V0, 1, 1, 0, 1, 1);
        add(1, 1, 0, V1, 1, 1, 0, 1, 2);
        add(1, 1, 0, V2, 1, 1, 0, 1, 3);
        add(1, 1, 1, V3, 1, 1, 0, 1, 4);
        add_drain_done(1, 4);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0; en = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
        en1 = 1'b0; in_valid1 = 1'b0; in_last1 = 1'b0; in_data1 = '0;
        sb_reset();
        repeat (3) @(posedge clock);
        #1;
        chk("reset.data_out", data_out, 32'h0);
        chk("reset.active", active_out, 1'b0);
        chk("reset.busy", busy, 1'b0);
        chk("reset.done", done, 1'b0);
        chk("reset.vec_count", vec_count, 32'h0);
        chk("reset.ready_en0", in_ready, 1'b0);
        rst_n = 1'b1;
        @(posedge clock);
        #1;

        load_tile1();
        run_table("tile1");

        add(1, 1, 0, V0, 1, 1, 0, 1, 1);
        add(1, 1, 0, V1, 1, 1, 0, 1, 2);
        add(1, 0, 1, $urandom, 1, 0, 0, 1, 2);
        add(1, 0, 0, $urandom, 1, 0, 0, 1, 2);
        add(1, 1, 0, V2, 1, 1, 0, 1, 3);
        add(1, 1, 1, V3, 1, 1, 0, 1, 4);
        add_drain_done(1, 4);
        run_table("bubble");

        add(1, 1, 0, V0, 1, 1, 0, 1, 1);
        add(1, 1, 0, V1, 1, 1, 0, 1, 2);
        add(0, 1, 0, V2, 0, 0, 0, 1, 2);
        add(1, 1, 0, V2, 1, 1, 0, 1, 3);
        add(1, 1, 1, V3, 1, 1, 0, 1, 4);
        add_drain_done(0, 4);
        run_table("en_stall");

        add(1, 1, 1, VS, 1, 1, 0, 1, 1);
        add_drain_done(1, 1);
        run_table("single");

        add(1, 1, 1, V0, 1, 1, 0, 1, 1);
        add(1, 0, 0, $urandom, 0, 1, 0, 1, 1);
        run_table("pre_abort");
        rst_n = 1'b0;
        #1;
        chk("abort.data_out", data_out, 32'h0);
        chk("abort.active", active_out, 1'b0);
        chk("abort.busy", busy, 1'b0);
        chk("abort.vec_count", vec_count, 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clock);
            #1;
            chk($sformatf("abort[%0d].done", k), done, 1'b0);
        end
        rst_n = 1'b1;
        sb_reset();
        @(posedge clock);
        #1;
        load_tile1();
        run_table("after_abort");

        en1 = 1'b1; in_valid1 = 1'b1; in_last1 = 1'b1; in_data1 = 8'd3;
        #1;
        chk("r1.in_ready", in_ready1, 1'b1);
        @(posedge clock);
        #1;
        in_valid1 = 1'b0; in_last1 = 1'b0; in_data1 = 8'hAA;
        chk("r1.c1.data_out", data_out1, 32'd3);
        chk("r1.c1.active", active_out1, 1'b1);
        chk("r1.c1.done", done1, 1'b0);
        chk("r1.c1.busy", busy1, 1'b1);
        chk("r1.c1.vec_count", vec_count1, 32'd1);
        @(posedge clock);
        #1;
        chk("r1.c2.done", done1, 1'b1);
        chk("r1.c2.active", active_out1, 1'b0);
        chk("r1.c2.busy", busy1, 1'b0);
        chk("r1.c2.data_out", data_out1, 32'd3);
        @(posedge clock);
        #1;
        chk("r1.c3.done", done1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
